// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl
//   Miss-handling and line-fill controller for the instruction cache. It is the
//   only writer of the 64-entry tag/valid/data arrays. On a miss it issues a
//   line-aligned burst read, assembles LINE_BEATS beats into one line, then
//   writes tag, valid and line to the arrays in a single WRITE cycle. It also
//   sequences a full-cache invalidate (one set per cycle).
//
//   Optional build macro ICACHE_FILL_PERF_EN: when defined, miss_count counts
//   IDLE->FILL transitions (wraps at 2^32). When undefined it is tied to 0 and
//   no counter flops exist.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_addr    fetch request and address
//   hit                   external tag-compare result for req_addr
//   flush                 one-cycle pulse: invalidate all sets
//   stall                 fetch must hold (combinational)
//   mem_read/mem_addr     burst read request, line-aligned address
//   mem_resp/mem_rdata    one returned beat per mem_resp cycle, lowest first
//   arr_load/arr_windex   array write strobe and index
//   arr_tag/arr_valid     tag and valid bit written
//   arr_line              line written, beat k at [k*BEAT_W +: BEAT_W]
//   miss_count            performance counter
module icache_fill_ctrl #(
   parameter int BEAT_W     = 64,
   parameter int LINE_BEATS = 4,
   parameter int IDX_W      = 6,
   parameter int TAG_W      = 21
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   input  logic [31:0]                  req_addr,
   input  logic                         hit,
   input  logic                         flush,
   output logic                         stall,
   output logic                         mem_read,
   output logic [31:0]                  mem_addr,
   input  logic                         mem_resp,
   input  logic [BEAT_W-1:0]            mem_rdata,
   output logic                         arr_load,
   output logic [IDX_W-1:0]             arr_windex,
   output logic [TAG_W-1:0]             arr_tag,
   output logic                         arr_valid,
   output logic [BEAT_W*LINE_BEATS-1:0] arr_line,
   output logic [31:0]                  miss_count
);
   localparam int LINE_W = BEAT_W * LINE_BEATS;
   localparam int OFF_W  = 32 - IDX_W - TAG_W;
   localparam int BC_W   = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
   localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(LINE_BEATS - 1);
   localparam logic [31:0]     OFF_MASK  = (32'd1 << OFF_W) - 32'd1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   logic [1:0]                         state_q, state_d;
   logic                               flush_pend_q, flush_pend_d;
   logic [BC_W-1:0]                    beat_cnt_q, beat_cnt_d;
   logic [LINE_BEATS-1:0][BEAT_W-1:0]  line_q, line_d, line_nxt;
   logic                               mem_read_q, mem_read_d;
   logic [31:0]                        mem_addr_q, mem_addr_d;
   logic                               arr_load_q, arr_load_d;
   logic [IDX_W-1:0]                   arr_windex_q, arr_windex_d;
   logic [TAG_W-1:0]                   arr_tag_q, arr_tag_d;
   logic                               arr_valid_q, arr_valid_d;
   logic [LINE_W-1:0]                  arr_line_q, arr_line_d;
   logic                               wr_bypass;

   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      beat_cnt_d   = beat_cnt_q;
      line_d       = line_q;
      mem_read_d   = mem_read_q;
      mem_addr_d   = mem_addr_q;
      arr_load_d   = arr_load_q;
      arr_windex_d = arr_windex_q;
      arr_tag_d    = arr_tag_q;
      arr_valid_d  = arr_valid_q;
      arr_line_d   = arr_line_q;
      // line as it looks with the current beat merged in; the last beat goes
      // straight to arr_line without a round trip through line_q
      line_nxt             = line_q;
      line_nxt[beat_cnt_q] = mem_rdata;
      case (state_q)
         S_IDLE: begin
            if (flush || flush_pend_q) begin
               state_d      = S_FLUSH;
               flush_pend_d = 1'b0;
               arr_load_d   = 1'b1;
               arr_windex_d = '0;
               arr_valid_d  = 1'b0;
               arr_tag_d    = '0;
               arr_line_d   = '0;
            end else if (req_valid && !hit) begin
               state_d    = S_FILL;
               mem_read_d = 1'b1;
               mem_addr_d = req_addr & ~OFF_MASK;
            end
         end
         S_FILL: begin
            if (flush) flush_pend_d = 1'b1;
            if (mem_resp) begin
               line_d = line_nxt;
               if (beat_cnt_q == LAST_BEAT) begin
                  beat_cnt_d   = '0;
                  mem_read_d   = 1'b0;
                  state_d      = S_WRITE;
                  arr_load_d   = 1'b1;
                  arr_windex_d = mem_addr_q[OFF_W +: IDX_W];
                  arr_tag_d    = mem_addr_q[31 -: TAG_W];
                  arr_valid_d  = 1'b1;
                  arr_line_d   = line_nxt;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (flush) flush_pend_d = 1'b1;
            arr_load_d = 1'b0;
            state_d    = S_IDLE;
         end
         S_FLUSH: begin
            if (arr_windex_q == {IDX_W{1'b1}}) begin
               state_d    = S_IDLE;
               arr_load_d = 1'b0;
            end else begin
               arr_windex_d = arr_windex_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         flush_pend_q <= 1'b0;
         beat_cnt_q   <= '0;
         line_q       <= '0;
         mem_read_q   <= 1'b0;
         mem_addr_q   <= '0;
         arr_load_q   <= 1'b0;
         arr_windex_q <= '0;
         arr_tag_q    <= '0;
         arr_valid_q  <= 1'b0;
         arr_line_q   <= '0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         beat_cnt_q   <= beat_cnt_d;
         line_q       <= line_d;
         mem_read_q   <= mem_read_d;
         mem_addr_q   <= mem_addr_d;
         arr_load_q   <= arr_load_d;
         arr_windex_q <= arr_windex_d;
         arr_tag_q    <= arr_tag_d;
         arr_valid_q  <= arr_valid_d;
         arr_line_q   <= arr_line_d;
      end
   end

   // In WRITE the arrays forward datain to a matching read index, so a fetch
   // to the line being written is satisfied this cycle.
   assign wr_bypass = (state_q == S_WRITE) && (req_addr[OFF_W +: IDX_W] == arr_windex_q);
   assign stall     = ((state_q != S_IDLE) && !wr_bypass) || (req_valid && !hit) || flush_pend_q;

   assign mem_read   = mem_read_q;
   assign mem_addr   = mem_addr_q;
   assign arr_load   = arr_load_q;
   assign arr_windex = arr_windex_q;
   assign arr_tag    = arr_tag_q;
   assign arr_valid  = arr_valid_q;
   assign arr_line   = arr_line_q;

`ifdef ICACHE_FILL_PERF_EN
   logic [31:0] miss_count_q;
   logic        miss_start;
   assign miss_start = (state_q == S_IDLE) && !(flush || flush_pend_q) && req_valid && !hit;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          miss_count_q <= '0;
      else if (miss_start) miss_count_q <= miss_count_q + 32'd1;
   end
   assign miss_count = miss_count_q;
`else
   assign miss_count = '0;
`endif
endmodule

// File: tb/tb_icache_fill_ctrl.sv
module tb_icache_fill_ctrl;
   logic         clk = 1'b0, rst_n = 1'b0;
   logic         req_valid = 1'b0, hit = 1'b0, flush = 1'b0, mem_resp = 1'b0;
   logic [31:0]  req_addr = '0;
   logic [63:0]  mem_rdata = '0;
   logic         stall, mem_read, arr_load, arr_valid;
   logic [31:0]  mem_addr, miss_count;
   logic [5:0]   arr_windex;
   logic [20:0]  arr_tag;
   logic [255:0] arr_line;

   always #5 clk = ~clk;

   icache_fill_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .hit(hit),
      .flush(flush), .stall(stall), .mem_read(mem_read), .mem_addr(mem_addr),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata), .arr_load(arr_load),
      .arr_windex(arr_windex), .arr_tag(arr_tag), .arr_valid(arr_valid),
      .arr_line(arr_line), .miss_count(miss_count)
   );

   // Expected array writes in order; the model cache decides hit/miss.
   typedef struct { logic [5:0] idx; logic [20:0] tag; logic vld; logic [255:0] line; } wr_t;
   wr_t          expq[$];
   logic         mv[64];
   logic [20:0]  mt[64];
   int           nerr = 0, nchk = 0, exp_miss = 0;
   logic [5:0]   lw_idx;
   logic [20:0]  lw_tag;
   logic [255:0] lw_line;
   logic [31:0]  lw_maddr;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Every array write is compared against the next expected write.
   always @(negedge clk) begin : mon
      wr_t e;
      if (rst_n && arr_load) begin
         if (expq.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL unexpected_write: got idx %0h expected no write", arr_windex);
         end else begin
            e = expq.pop_front();
            chk("wr_idx", arr_windex, e.idx);
            chk("wr_tag", arr_tag, e.tag);
            chk("wr_vld", arr_valid, e.vld);
            chk("wr_line", arr_line, e.line);
            lw_idx = arr_windex; lw_tag = arr_tag; lw_line = arr_line;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   function automatic logic [31:0] mc_exp();
`ifdef ICACHE_FILL_PERF_EN
      return 32'(exp_miss);
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick(); @(posedge clk); #1; endtask

   task automatic push_flush();
      wr_t e;
      for (int i = 0; i < 64; i++) begin
         e.idx = 6'(i); e.tag = '0; e.vld = 1'b0; e.line = '0;
         expq.push_back(e);
         mv[i] = 1'b0;
      end
   endtask

   // Entered at the first flush cycle; leaves in the IDLE cycle after it.
   task automatic flush_body();
      for (int i = 0; i < 64; i++) begin
         #1;
         chk("flush_load", arr_load, 1'b1);
         chk("flush_stall", stall, 1'b1);
         tick();
      end
      #1;
      chk("flush_done_load", arr_load, 1'b0);
      chk("flush_done_stall", stall, 1'b0);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      push_flush();
      tick();
      flush = 1'b0;
      flush_body();
   endtask

   // gap<0: random 0..3 idle cycles before each beat. fbeat>=0: flush pulse on that beat.
   task automatic do_miss(input logic [31:0] addr, input int gap, input int fbeat,
                          input bit junk, input bit fixed);
      logic [255:0] line;
      logic [63:0]  d;
      wr_t          e;
      int           n;
      line = '0;
      if (junk) begin
         mem_resp = 1'b1; mem_rdata = {$urandom, $urandom};
         tick();
         mem_resp = 1'b0;
      end
      req_valid = 1'b1; req_addr = addr; hit = 1'b0;
      #1 chk("miss_stall", stall, 1'b1);
      tick();
      exp_miss++;
      chk("fill_mem_read", mem_read, 1'b1);
      chk("fill_mem_addr", mem_addr, addr & 32'hFFFF_FFE0);
      lw_maddr = mem_addr;
      for (int k = 0; k < 4; k++) begin
         n = (gap >= 0) ? gap : int'($urandom_range(3, 0));
         for (int g = 0; g < n; g++) begin
            chk("gap_mem_read", mem_read, 1'b1);
            chk("gap_mem_addr", mem_addr, addr & 32'hFFFF_FFE0);
            #1 chk("gap_stall", stall, 1'b1);
            tick();
         end
         d = fixed ? 64'hA0 + 64'(k) : {$urandom, $urandom};
         line[k*64 +: 64] = d;
         mem_resp = 1'b1; mem_rdata = d; flush = (k == fbeat);
         chk("beat_mem_read", mem_read, 1'b1);
         if (k == 3) begin
            e.idx = addr[10:5]; e.tag = addr[31:11]; e.vld = 1'b1; e.line = line;
            expq.push_back(e);
            mv[addr[10:5]] = 1'b1; mt[addr[10:5]] = addr[31:11];
            if (fbeat >= 0) push_flush();
         end
         tick();
         mem_resp = 1'b0; flush = 1'b0;
      end
      hit = 1'b1;   // refetch hits through the array bypass
      chk("write_mem_read", mem_read, 1'b0);
      #1 chk("write_stall", stall, fbeat >= 0);
      tick();
      chk("post_write_load", arr_load, 1'b0);
      #1 chk("post_write_stall", stall, fbeat >= 0);
      req_valid = 1'b0; hit = 1'b0;
      if (fbeat >= 0) begin
         tick();
         flush_body();
      end
   endtask

   task automatic do_hit(input logic [31:0] addr);
      req_valid = 1'b1; req_addr = addr; hit = 1'b1;
      #1 chk("hit_stall", stall, 1'b0);
      tick();
      chk("hit_mem_read", mem_read, 1'b0);
      req_valid = 1'b0; hit = 1'b0;
   endtask

   task automatic do_abort(input logic [31:0] addr);
      req_valid = 1'b1; req_addr = addr; hit = 1'b0;
      tick();
      exp_miss++;
      chk("abort_mem_read", mem_read, 1'b1);
      req_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mem_resp = 1'b1; mem_rdata = {$urandom, $urandom};
         tick();
      end
      mem_resp = 1'b0;
      rst_n = 1'b0;
      exp_miss = 0;
      #1;
      chk("abort_mem_read_drop", mem_read, 1'b0);
      chk("abort_load", arr_load, 1'b0);
      chk("abort_miss_count", miss_count, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("abort_idle_mem_read", mem_read, 1'b0);
   endtask

   initial begin : main
      logic [31:0] recent[4];
      logic [31:0] a;
      for (int i = 0; i < 64; i++) begin mv[i] = 1'b0; mt[i] = '0; end
      for (int i = 0; i < 4; i++) recent[i] = 32'(i) << 5;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_load", arr_load, 1'b0);
      chk("rst_windex", arr_windex, 6'd0);
      chk("rst_tag", arr_tag, 21'd0);
      chk("rst_valid", arr_valid, 1'b0);
      chk("rst_line", arr_line, 256'd0);
      chk("rst_miss_count", miss_count, 32'd0);
      rst_n = 1'b1;
      tick();
      // 1: basic fill with literal expectations
      do_miss(32'h0000_1234, 0, -1, 1'b0, 1'b1);
      chk("t1_mem_addr", lw_maddr, 32'h0000_1220);
      chk("t1_idx", lw_idx, 6'h11);
      chk("t1_tag", lw_tag, 21'h000002);
      chk("t1_beat0", lw_line[63:0], 64'hA0);
      chk("t1_beat3", lw_line[255:192], 64'hA3);
      // 2: gapped beats, stray mem_resp in IDLE
      do_miss(32'h0ABC_DE40, 2, -1, 1'b1, 1'b0);
      // 3: flush from IDLE
      do_flush();
      // 4: flush during second beat
      do_miss(32'h0055_5560, 0, 1, 1'b0, 1'b0);
      // 5: reset mid-fill, then a clean fill to index 2
      do_abort(32'h00F0_0100);
      do_miss(32'h0000_0040, 1, -1, 1'b0, 1'b0);
      chk("t5_idx", lw_idx, 6'h02);
      chk("t5_tag", lw_tag, 21'h0);
      // 6: 3 misses + 2 hits since reset
      do_hit(32'h0000_0040);
      do_miss(32'h0000_1000, 0, -1, 1'b0, 1'b0);
      do_hit(32'h0000_0044);
      do_miss(32'h0000_2000, -1, -1, 1'b0, 1'b0);
      chk("t6_miss_count", miss_count, mc_exp());
`ifdef ICACHE_FILL_PERF_EN
      chk("t6_miss_count_lit", miss_count, 32'd3);
`else
      chk("t6_miss_count_lit", miss_count, 32'd0);
`endif
      // randomized traffic against the model cache
      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(9, 0) == 0) begin
            do_flush();
         end else begin
            if ($urandom_range(9, 0) < 4) a = recent[$urandom_range(3, 0)] | 32'($urandom_range(31, 0));
            else a = $urandom;
            if (mv[a[10:5]] && mt[a[10:5]] == a[31:11]) begin
               do_hit(a);
            end else begin
               do_miss(a, -1, ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
                       1'($urandom_range(1, 0)), 1'b0);
               recent[$urandom_range(3, 0)] = a;
            end
         end
      end
      chk("final_miss_count", miss_count, mc_exp());
      tick(); tick();
      chk("final_queue_empty", 32'(expq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
